gpio_axi_arbiter: RTL and testbench
===================================

GPIO_AXI_ARBITER -- requirements
Module: gpio_axi_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, 64, cycles allowed per AXI transaction before abort; ADDR_W, 32, address width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  async active-low reset.
- reqN_valid  in  1  requester N (N=0,1) has a transaction pending.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  target address.
- reqN_wdata  in  32  write data.
- reqN_strobe  in  4  write byte strobes.
- reqN_ready  out  1  one-cycle pulse: request captured.
- reqN_done  out  1  one-cycle pulse: transaction finished.
- reqN_err  out  1  valid with reqN_done: timeout abort.
- reqN_rdata  out  32  read data, valid with reqN_done, held until the next done to N.
- WAddress, Wdata, strobe  out  ADDR_W/32/4  AXI-lite write address/data/strobes.
- AWvalid, Wvalid, Bready  out  1  AXI-lite write handshakes.
- AWready, Wready, Bvalid  in  1  slave write handshakes.
- RAddress  out  ADDR_W  AXI-lite read address.
- ARvalid, Rready  out  1  read handshakes.
- ARready, Rvalid  in  1  slave read handshakes.
- Rdata  in  32  slave read data.

Function
REQ-004 FSM states SHALL be IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-005 In IDLE with any reqN_valid, the block SHALL grant one requester, pulse its reqN_ready, register addr/wdata/strobe/write, and move to WADDR or RADDR next cycle.
REQ-006 When both request simultaneously, grant SHALL go to the requester not granted last (round-robin; last_grant resets to 1 so requester 0 wins first).
REQ-007 WADDR: AWvalid and Wvalid SHALL assert together; each SHALL deassert independently the cycle after its ready is sampled high; both completed -> WRESP.
REQ-008 WRESP: Bready SHALL be high until Bvalid is sampled, then -> DONE.
REQ-009 RADDR: ARvalid high until ARready sampled, then -> RDATA with Rready high; on Rvalid, Rdata SHALL be latched into the granted reqN_rdata and -> DONE.
REQ-010 DONE: pulse reqN_done (reqN_err=0) for one cycle, return to IDLE; minimum write latency from reqN_ready to done = 3 cycles with zero-wait slave.
REQ-011 A 16-bit timeout counter SHALL clear on leaving IDLE and increment each cycle; reaching TIMEOUT-1 outside IDLE/DONE SHALL drop all AXI valids/readies, pulse reqN_done with reqN_err=1, return to IDLE; reqN_rdata unchanged on abort.
REQ-012 Address/data outputs SHALL remain stable while the corresponding valid is high.
REQ-013 Requests arriving during a transaction SHALL wait; no request SHALL be dropped while reqN_valid stays high.

Reset
REQ-014 While reset=0: state IDLE, all valid/ready/done/err outputs 0, WAddress/Wdata/RAddress/strobe/reqN_rdata 0, last_grant 1, counter 0.
REQ-015 Reset asserted mid-transaction SHALL abort silently (no done pulse); first grant after release SHALL follow REQ-006.

Structure
REQ-016 A shared package gpio_arb_pkg SHALL hold the state enum and default TIMEOUT constant.
REQ-017 Round-robin grant logic SHALL be one sub-module, gpio_rr_grant (2 requests, last_grant in, one-hot grant out).

Verification
REQ-018 Req0 write 0x00000EFA <- 0xABCDEFFF, strobe 0xF, zero-wait slave -> AWvalid/Wvalid one cycle, Bready until Bvalid, req0_done at +3, err=0.
REQ-019 Req1 read 0x0544C584, slave returns Rdata=0x000000AA after 2 wait cycles -> req1_rdata=0x000000AA with req1_done.
REQ-020 Both valid same cycle, three times each -> grants alternate 0,1,0,1,0,1.
REQ-021 Slave never asserts Bvalid, TIMEOUT=8 -> all valids drop, req0_done=1 with req0_err=1 at cycle 7 after leaving IDLE.
REQ-022 Wready delayed 4 cycles after AWready -> AWvalid drops after 1 cycle, Wvalid held 4, single Bready phase.
REQ-023 Reset pulled low in RDATA -> outputs zero next edge, no done pulse; pending req1 granted first after release.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO-to-AXI-lite arbiter.
// Holds the transaction FSM state encoding, the default abort timeout and
// the width of the per-transaction cycle counter.
package gpio_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_e;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/gpio_rr_grant.sv
// Two-way round-robin grant.
// Ports:
//   req        in  [1:0]  pending requests (bit N = requester N)
//   last_grant in  1      index of the requester granted most recently
//   grant      out [1:0]  one-hot grant, all zero when nothing is requested
// On contention the requester that was not granted last wins.
module gpio_rr_grant (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last_grant)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/gpio_axi_arbiter.sv
// Arbitrates two simple GPIO-side requesters onto one AXI-lite master port.
// One transaction is in flight at a time; each is aborted with an error if
// it has not completed within TIMEOUT cycles.
// Ports:
//   clock, reset             clock and asynchronous active-low reset
//   reqN_valid/write/addr/wdata/strobe   request from requester N (N=0,1)
//   reqN_ready               one-cycle pulse when the request is captured
//   reqN_done/err            one-cycle completion pulse, err = timeout abort
//   reqN_rdata               last read data returned to requester N
//   WAddress/Wdata/strobe, AWvalid/Wvalid/Bready, AWready/Wready/Bvalid
//                            AXI-lite write channels
//   RAddress, ARvalid/Rready, ARready/Rvalid/Rdata
//                            AXI-lite read channels
module gpio_axi_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [3:0]        req0_strobe,
  output logic              req0_ready,
  output logic              req0_done,
  output logic              req0_err,
  output logic [31:0]       req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [3:0]        req1_strobe,
  output logic              req1_ready,
  output logic              req1_done,
  output logic              req1_err,
  output logic [31:0]       req1_rdata,
  output logic [ADDR_W-1:0] WAddress,
  output logic [31:0]       Wdata,
  output logic [3:0]        strobe,
  output logic              AWvalid,
  output logic              Wvalid,
  output logic              Bready,
  input  logic              AWready,
  input  logic              Wready,
  input  logic              Bvalid,
  output logic [ADDR_W-1:0] RAddress,
  output logic              ARvalid,
  output logic              Rready,
  input  logic              ARready,
  input  logic              Rvalid,
  input  logic [31:0]       Rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              gnt_id;
  logic              aw_done, w_done;
  logic [1:0]        grant;
  logic              take;
  logic              abort;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_strobe;

  gpio_rr_grant u_grant (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gating with reset keeps ready pulses off while reset is held, even
  // though the state register already sits in IDLE.
  assign take  = reset && (state == IDLE) && (|grant);
  assign abort = (state != IDLE) && (state != DONE) && (cnt == TO_LAST);

  always_comb begin
    sel_write  = grant[1] ? req1_write  : req0_write;
    sel_addr   = grant[1] ? req1_addr   : req0_addr;
    sel_wdata  = grant[1] ? req1_wdata  : req0_wdata;
    sel_strobe = grant[1] ? req1_strobe : req0_strobe;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      WAddress   <= '0;
      Wdata      <= '0;
      strobe     <= '0;
      RAddress   <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      state <= state_nxt;
      // Counts cycles spent outside IDLE; starts at 0 in the first busy cycle.
      cnt   <= (state == IDLE) ? '0 : cnt + 1'b1;
      if (take) begin
        gnt_id     <= grant[1];
        last_grant <= grant[1];
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        if (sel_write) begin
          WAddress <= sel_addr;
          Wdata    <= sel_wdata;
          strobe   <= sel_strobe;
        end else begin
          RAddress <= sel_addr;
        end
      end
      // Address and data channels complete independently.
      if (AWvalid && AWready) aw_done <= 1'b1;
      if (Wvalid && Wready)   w_done  <= 1'b1;
      if ((state == RDATA) && Rvalid && !abort) begin
        if (gnt_id) req1_rdata <= Rdata;
        else        req0_rdata <= Rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    AWvalid    = 1'b0;
    Wvalid     = 1'b0;
    Bready     = 1'b0;
    ARvalid    = 1'b0;
    Rready     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    req0_err   = 1'b0;
    req1_err   = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_nxt  = sel_write ? WADDR : RADDR;
        end
      end
      WADDR: begin
        AWvalid = !aw_done;
        Wvalid  = !w_done;
        if ((aw_done || AWready) && (w_done || Wready)) state_nxt = WRESP;
      end
      WRESP: begin
        Bready = 1'b1;
        if (Bvalid) state_nxt = DONE;
      end
      RADDR: begin
        ARvalid = 1'b1;
        if (ARready) state_nxt = RDATA;
      end
      RDATA: begin
        Rready = 1'b1;
        if (Rvalid) state_nxt = DONE;
      end
      DONE: begin
        req0_done = !gnt_id;
        req1_done = gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Timeout overrides whatever the channel state wanted this cycle.
    if (abort) begin
      AWvalid   = 1'b0;
      Wvalid    = 1'b0;
      Bready    = 1'b0;
      ARvalid   = 1'b0;
      Rready    = 1'b0;
      req0_done = !gnt_id;
      req1_done = gnt_id;
      req0_err  = !gnt_id;
      req1_err  = gnt_id;
      state_nxt = IDLE;
    end
  end

endmodule

// File: tb/tb_gpio_axi_arbiter.sv
// Self-checking bench for gpio_axi_arbiter (TIMEOUT=8).
module tb_gpio_axi_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_strobe, req1_strobe;
  logic        req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] WAddress, Wdata, RAddress, Rdata;
  logic [3:0]  strobe;
  logic        AWvalid, Wvalid, Bready, AWready, Wready, Bvalid;
  logic        ARvalid, Rready, ARready, Rvalid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int aw_n, w_n, b_n, r_n;
  int ready_cyc[2];
  int done_cyc[2];
  int done_cnt[2];
  logic [31:0] model_rdata[2];
  exp_t q0[$];
  exp_t q1[$];
  int   gnt_log[$];

  // slave behaviour knobs
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_never = 0, r_never = 0;
  logic [31:0] r_val = 32'h0;

  gpio_axi_arbiter #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strobe(req0_strobe), .req0_ready(req0_ready),
    .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strobe(req1_strobe), .req1_ready(req1_ready),
    .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .WAddress(WAddress), .Wdata(Wdata), .strobe(strobe),
    .AWvalid(AWvalid), .Wvalid(Wvalid), .Bready(Bready),
    .AWready(AWready), .Wready(Wready), .Bvalid(Bvalid),
    .RAddress(RAddress), .ARvalid(ARvalid), .Rready(Rready),
    .ARready(ARready), .Rvalid(Rvalid), .Rdata(Rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // AXI-lite slave: each ready/valid answers after a programmable number of cycles
  initial begin : slave
    int awc, wc, bc, arc, rc;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    AWready = 0; Wready = 0; Bvalid = 0; ARready = 0; Rvalid = 0; Rdata = 0;
    forever begin
      @(negedge clock);
      Rdata   = r_val;
      AWready = AWvalid && (awc >= aw_dly);
      if (AWvalid && AWready) awc = 0; else if (AWvalid) awc++; else awc = 0;
      Wready  = Wvalid && (wc >= w_dly);
      if (Wvalid && Wready) wc = 0; else if (Wvalid) wc++; else wc = 0;
      Bvalid  = Bready && !b_never && (bc >= b_dly);
      if (Bready && Bvalid) bc = 0; else if (Bready) bc++; else bc = 0;
      ARready = ARvalid && (arc >= ar_dly);
      if (ARvalid && ARready) arc = 0; else if (ARvalid) arc++; else arc = 0;
      Rvalid  = Rready && !r_never && (rc >= r_dly);
      if (Rready && Rvalid) rc = 0; else if (Rready) rc++; else rc = 0;
    end
  end

  // Monitor: scoreboard pop on done, grant log, channel activity counters
  initial begin : monitor
    exp_t e;
    logic d, er;
    logic [31:0] rd;
    bit empty;
    forever begin
      @(negedge clock);
      for (int n = 0; n < 2; n++) begin
        d  = (n == 0) ? req0_done  : req1_done;
        er = (n == 0) ? req0_err   : req1_err;
        rd = (n == 0) ? req0_rdata : req1_rdata;
        if (d) begin
          done_cnt[n]++;
          done_cyc[n] = cyc;
          empty = (n == 0) ? (q0.size() == 0) : (q1.size() == 0);
          total++;
          if (empty) begin
            bad++;
            $display("FAIL unexpected_done req%0d: done=1 with nothing outstanding, required done=0", n);
          end else begin
            if (n == 0) e = q0.pop_front(); else e = q1.pop_front();
            if (er !== e.err || rd !== e.rdata) begin
              bad++;
              $display("FAIL done_req%0d: err=%0b rdata=%h, required err=%0b rdata=%h",
                       n, er, rd, e.err, e.rdata);
            end
          end
          if (er) begin
            total++;
            if ({AWvalid, Wvalid, Bready, ARvalid, Rready} !== 5'b0) begin
              bad++;
              $display("FAIL abort_drop req%0d: AW/W/B/AR/R=%b, required 00000", n,
                       {AWvalid, Wvalid, Bready, ARvalid, Rready});
            end
          end
        end else if (er) begin
          total++; bad++;
          $display("FAIL err_without_done req%0d: err=1 done=0, required err=0", n);
        end
      end
      if (req0_ready && req1_ready) begin
        total++; bad++;
        $display("FAIL grant_onehot: ready0=1 ready1=1, required at most one");
      end else if (req0_ready) gnt_log.push_back(0);
      else if (req1_ready) gnt_log.push_back(1);
      aw_n += int'(AWvalid);
      w_n  += int'(Wvalid);
      b_n  += int'(Bready);
      r_n  += int'(Rready);
    end
  end

  task automatic issue(input int n, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input bit exp_err);
    exp_t e;
    bit seen;
    @(posedge clock); #1;
    if (!wr && !exp_err) model_rdata[n] = r_val;
    e.err   = exp_err;
    e.rdata = model_rdata[n];
    if (n == 0) begin
      q0.push_back(e);
      req0_write = wr; req0_addr = addr; req0_wdata = data; req0_strobe = strb; req0_valid = 1;
    end else begin
      q1.push_back(e);
      req1_write = wr; req1_addr = addr; req1_wdata = data; req1_strobe = strb; req1_valid = 1;
    end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      seen = (n == 0) ? req0_ready : req1_ready;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ready_req%0d: no ready pulse in 100 cycles, required one", n);
    end else ready_cyc[n] = cyc;
    @(posedge clock); #1;
    if (n == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_done(input int n, input int target);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock); #1;
      ok = (done_cnt[n] >= target);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_done_req%0d: done count %0d, required %0d", n, done_cnt[n], target);
    end
  endtask

  task automatic check_latency(input string name, input int n, input int req_lat);
    total++;
    if (done_cyc[n] - ready_cyc[n] !== req_lat) begin
      bad++;
      $display("FAIL %s: latency %0d, required %0d", name, done_cyc[n] - ready_cyc[n], req_lat);
    end
  endtask

  task automatic test_reset;
    reset = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 32'h1234; req0_wdata = 32'h55; req0_strobe = 4'hF;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strobe = 0;
    repeat (2) @(negedge clock);
    total++;
    if (req0_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready: ready0=%b, required 0", req0_ready);
    end
    total++;
    if ({AWvalid, Wvalid, Bready, ARvalid, Rready} !== 5'b0) begin
      bad++; $display("FAIL rst_axi_ctl: %b, required 00000", {AWvalid, Wvalid, Bready, ARvalid, Rready});
    end
    total++;
    if ({req0_done, req1_done, req0_err, req1_err} !== 4'b0) begin
      bad++; $display("FAIL rst_done_err: %b, required 0000", {req0_done, req1_done, req0_err, req1_err});
    end
    total++;
    if (WAddress !== 32'h0 || Wdata !== 32'h0 || RAddress !== 32'h0 || strobe !== 4'h0) begin
      bad++; $display("FAIL rst_axi_data: WA=%h WD=%h RA=%h S=%h, required all 0", WAddress, Wdata, RAddress, strobe);
    end
    total++;
    if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_rdata: %h %h, required 0 0", req0_rdata, req1_rdata);
    end
    req0_valid = 0;
    @(posedge clock); #1;
    reset = 1;
  endtask

  task automatic test_write;
    int d0 = done_cnt[0];
    aw_dly = 0; w_dly = 0; b_dly = 0;
    b_n = 0;
    issue(0, 1, 32'h0000_0EFA, 32'hABCD_EFFF, 4'hF, 0);
    @(negedge clock);
    total++;
    if (AWvalid !== 1'b1 || Wvalid !== 1'b1 || WAddress !== 32'h0000_0EFA ||
        Wdata !== 32'hABCD_EFFF || strobe !== 4'hF) begin
      bad++;
      $display("FAIL wr_addr_phase: AWv=%b Wv=%b WA=%h WD=%h S=%h, required 1 1 00000efa abcdefff f",
               AWvalid, Wvalid, WAddress, Wdata, strobe);
    end
    @(negedge clock);
    total++;
    if (AWvalid !== 1'b0 || Wvalid !== 1'b0 || Bready !== 1'b1) begin
      bad++;
      $display("FAIL wr_resp_phase: AWv=%b Wv=%b Bready=%b, required 0 0 1", AWvalid, Wvalid, Bready);
    end
    wait_done(0, d0 + 1);
    check_latency("wr_latency", 0, 3);
    total++;
    if (b_n !== 1) begin
      bad++; $display("FAIL wr_bready_cycles: %0d, required 1", b_n);
    end
  endtask

  task automatic test_read;
    int d1 = done_cnt[1];
    r_val = 32'h0000_00AA; r_dly = 2; ar_dly = 0;
    r_n = 0;
    issue(1, 0, 32'h0544_C584, 32'h0, 4'h0, 0);
    @(negedge clock);
    total++;
    if (ARvalid !== 1'b1 || RAddress !== 32'h0544_C584) begin
      bad++; $display("FAIL rd_addr_phase: ARv=%b RA=%h, required 1 0544c584", ARvalid, RAddress);
    end
    wait_done(1, d1 + 1);
    check_latency("rd_latency", 1, 5);
    total++;
    if (r_n !== 3) begin
      bad++; $display("FAIL rd_rready_cycles: %0d, required 3", r_n);
    end
    r_val = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    total++;
    if (req1_rdata !== model_rdata[1]) begin
      bad++; $display("FAIL rd_hold: rdata=%h, required %h", req1_rdata, model_rdata[1]);
    end
    r_dly = 0;
  endtask

  task automatic test_alternate;
    int d0 = done_cnt[0];
    int d1 = done_cnt[1];
    int got;
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) issue(0, 1, 32'h200 + k * 4, 32'h1000 + k, 4'hF, 0);
      end
      begin
        for (int k = 0; k < 3; k++) issue(1, 1, 32'h300 + k * 4, 32'h2000 + k, 4'h5, 0);
      end
    join
    wait_done(0, d0 + 3);
    wait_done(1, d1 + 3);
    for (int i = 0; i < 6; i++) begin
      got = (i < gnt_log.size()) ? gnt_log[i] : -1;
      total++;
      if (got !== (i % 2)) begin
        bad++; $display("FAIL rr_grant_%0d: granted %0d, required %0d", i, got, i % 2);
      end
    end
  endtask

  task automatic test_wready_delay;
    int d1 = done_cnt[1];
    aw_dly = 0; w_dly = 3; b_dly = 0;
    aw_n = 0; w_n = 0; b_n = 0;
    issue(1, 1, 32'h0000_0100, 32'h5A5A_A5A5, 4'h3, 0);
    wait_done(1, d1 + 1);
    total++;
    if (aw_n !== 1 || w_n !== 4 || b_n !== 1) begin
      bad++; $display("FAIL wready_delay: AW=%0d W=%0d B=%0d cycles, required 1 4 1", aw_n, w_n, b_n);
    end
    check_latency("wready_latency", 1, 6);
    w_dly = 0;
  endtask

  task automatic test_timeout;
    int d0 = done_cnt[0];
    int d1 = done_cnt[1];
    b_never = 1;
    issue(0, 1, 32'h0000_0040, 32'h1111_2222, 4'hF, 1);
    wait_done(0, d0 + 1);
    check_latency("wr_timeout_latency", 0, 8);
    b_never = 0;
    r_never = 1;
    r_val = 32'h7777_7777;
    issue(1, 0, 32'h0000_0080, 32'h0, 4'h0, 1);
    wait_done(1, d1 + 1);
    check_latency("rd_timeout_latency", 1, 8);
    r_never = 0;
  endtask

  task automatic test_reset_mid;
    int d0;
    int d1 = done_cnt[1];
    int got;
    r_val = 32'h0000_5555; r_dly = 20;
    issue(0, 0, 32'h0000_0044, 32'h0, 4'h0, 0);
    fork
      begin
        issue(1, 1, 32'h0000_0888, 32'hCAFE_0001, 4'hF, 0);
      end
      begin
        bit inr = 0;
        for (int i = 0; i < 20 && !inr; i++) begin
          @(negedge clock);
          inr = Rready;
        end
        total++;
        if (!inr) begin
          bad++; $display("FAIL mid_reach_rdata: Rready never 1, required 1");
        end
        d0 = done_cnt[0];
        reset = 0;
        #1;
        total++;
        if ({AWvalid, Wvalid, Bready, ARvalid, Rready} !== 5'b0 || RAddress !== 32'h0 ||
            req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin
          bad++;
          $display("FAIL mid_rst_outputs: ctl=%b RA=%h rd0=%h rd1=%h, required all 0",
                   {AWvalid, Wvalid, Bready, ARvalid, Rready}, RAddress, req0_rdata, req1_rdata);
        end
        repeat (3) @(negedge clock);
        total++;
        if (done_cnt[0] !== d0 || req1_ready !== 1'b0) begin
          bad++;
          $display("FAIL mid_rst_silent: done pulses %0d ready1=%b, required 0 0", done_cnt[0] - d0, req1_ready);
        end
        q0.delete();
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        foreach (q1[i]) q1[i].rdata = 32'h0;
        gnt_log.delete();
        @(posedge clock); #1;
        reset = 1;
      end
    join
    wait_done(1, d1 + 1);
    got = (gnt_log.size() > 0) ? gnt_log[0] : -1;
    total++;
    if (got !== 1) begin
      bad++; $display("FAIL mid_first_grant: granted %0d, required 1", got);
    end
    r_dly = 0;
  endtask

  initial begin : main
    done_cnt[0] = 0; done_cnt[1] = 0;
    model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
    aw_n = 0; w_n = 0; b_n = 0; r_n = 0;
    test_reset;
    test_write;
    test_read;
    test_alternate;
    test_wready_delay;
    test_timeout;
    test_reset_mid;
    repeat (3) @(negedge clock);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++; $display("FAIL outstanding: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
